ro_counter_bank_axil: RTL and testbench
=======================================

# ro_counter_bank_axil

Parametrised ring-oscillator frequency-measurement bank with an AXI4-Lite slave register interface. Drives per-channel enables to NUM_CH external ring oscillators, counts rising edges on each oscillator's divided output over a programmable gate window of ACLK cycles, and latches the results into readable count registers. Sits between the oscillator array and the AXI interconnect. It replaces the fixed single-oscillator register block with configurable channel count, gating, continuous mode and overflow detection.

## Interface
- NUM_CH, 10, number of oscillator channels (1..32)
- CNT_WIDTH, 32, edge-counter width (8..32); count registers are zero-extended to 32 bits
- C_S_AXI_ADDR_WIDTH, 8, AXI4-Lite byte-address width; must cover 0x10 + 4*NUM_CH
- ACLK  in  1  sole clock; all logic is on the rising edge
- ARESET  in  1  asynchronous, active-high reset
- ro_in  in  NUM_CH  divided oscillator outputs, asynchronous to ACLK; toggle rate < ACLK/4
- ro_en  out  NUM_CH  oscillator enables (= ENABLE register)
- irq  out  1  level, high while STATUS.done=1 and CTRL.irq_en=1
- S_AXI_AW*/W*/B*/AR*/R*  AXI4-Lite slave, 32-bit data, WSTRB honoured per byte, PROT ignored

## Operation
- Register map:
  - 0x00 CTRL: bit0 start (self-clearing, reads 0), bit1 continuous, bit2 irq_en, bit3 clear (self-clearing; zeroes all COUNT registers and the STATUS.ovf flag)
  - 0x04 STATUS: bit0 busy (RO), bit1 done (W1C), bit2 ovf (W1C, sticky)
  - 0x08 GATE: gate length in ACLK cycles; 0 is treated as 1
  - 0x0C ENABLE: bits[NUM_CH-1:0] drive ro_en; upper bits read 0
  - 0x10+4k COUNT[k], k < NUM_CH: latched result (RO)
  - All other addresses: reads return 0, writes are ignored; response is always OKAY.
- Input path: each ro_in bit passes through a 2-FF synchroniser, then a third flop for rising-edge detection. One count is registered per detected rising edge.
- FSM:
  - IDLE -> ARM when start=1. start is ignored when the FSM is not in IDLE.
  - ARM (1 cycle): zero the working counters; load the gate down-counter with max(GATE,1).
  - COUNT: increment the counter of each enabled channel on its edge; decrement the gate counter; go to LATCH when the gate counter reaches 1.
  - LATCH (1 cycle): copy the working counters into COUNT[k].
  - DONE (1 cycle): set done. If continuous=1, go to ARM, otherwise go to IDLE.
- busy = 1 in ARM, COUNT and LATCH.
- Disabled channels do not count; their LATCH value is 0.
- Saturation: a working counter at 2^CNT_WIDTH-1 holds its value, and ovf is set.
- Clearing continuous mid-run finishes the current window, then goes to IDLE.
- Writes to GATE or ENABLE during busy take effect at the next ARM; ro_en updates immediately.

## Timing
- Reset values: every register, COUNT and counter = 0, FSM in IDLE, ro_en = 0, irq = 0.
- AXI write handshake:
  - AWREADY and WREADY assert together for one cycle when AWVALID, WVALID and !BVALID are all high.
  - BVALID asserts the next cycle with BRESP = 0 and holds until BREADY.
- AXI read handshake:
  - ARREADY asserts for one cycle when ARVALID and !RVALID are both high.
  - RVALID and RDATA follow one cycle later and hold until RREADY.
- Reads and writes are independent; back-to-back transfers are allowed, giving 1 transfer per 2 cycles per channel.
- Start latency: a start write accepted in cycle t puts the FSM in ARM at t+1. COUNT covers cycles t+2 .. t+1+G.
- Result latency: COUNT[k] updates at t+2+G, and done=1 from t+3+G.
- Edge latency: an edge on ro_in is counted 3 cycles after it is sampled. Edges in the last 3 cycles of a window fall into the next window (continuous mode) or are lost.
- Simultaneous events: hardware set of done/ovf wins over a W1C in the same cycle. A clear write during busy zeroes COUNT and ovf, but the next LATCH overwrites COUNT.
- ARESET asserted mid-window: immediate asynchronous return to reset values. Any outstanding AXI response is dropped.

## Test plan
- Reset: assert ARESET during COUNT, then read all registers. All read 0, ro_en=0, FSM idle.
- AXI register access:
  - Write ENABLE=0x3FF, then GATE=0x00000064, then read both back. Expect 0x3FF and 0x64; ro_en=0x3FF.
  - Read 0xFC. Expect 0 with OKAY.
- Single measurement, NUM_CH=10, GATE=1000:
  - Stimulus: ro_in[k] toggles at period 8*(k+1) cycles (rise every 8*(k+1)); start written.
  - Expect COUNT[k] = floor(1000/(8*(k+1))) ±1, busy=0, done=1, irq=1 when irq_en=1.
  - W1C done: irq drops the next cycle.
- Disabled channel: ENABLE=0x001 with all inputs toggling. Expect only COUNT[0] nonzero.
- Saturation, CNT_WIDTH=8:
  - Stimulus: GATE=2000, ro_in[0] rise every 4 cycles.
  - Expect COUNT[0]=255 and ovf=1.
  - After a clear write: COUNT[0]=0 and ovf=0.
- Continuous mode: continuous=1, GATE=50. Expect done pulses spaced exactly 53 cycles apart.
- Continuous stop and restart:
  - Clear continuous: FSM stops after the current window.
  - Start written while busy: ignored, no extra window.

Source files
------------

// File: rtl/ro_counter_bank_axil_if.sv
// AXI4-Lite slave bundle for the ring-oscillator counter bank (32-bit data).
// Latency: wires only; no registered stages of its own.
// Backpressure: plain AXI4-Lite valid/ready on every channel.
// Ports: AW/W/B write channels, AR/R read channels; PROT carried but unused.
interface ro_counter_bank_axil_if #(
  parameter int ADDR_W = 8
);
  logic [ADDR_W-1:0] AWADDR;
  logic [2:0]        AWPROT;
  logic              AWVALID;
  logic              AWREADY;
  logic [31:0]       WDATA;
  logic [3:0]        WSTRB;
  logic              WVALID;
  logic              WREADY;
  logic [1:0]        BRESP;
  logic              BVALID;
  logic              BREADY;
  logic [ADDR_W-1:0] ARADDR;
  logic [2:0]        ARPROT;
  logic              ARVALID;
  logic              ARREADY;
  logic [31:0]       RDATA;
  logic [1:0]        RRESP;
  logic              RVALID;
  logic              RREADY;

  modport master (
    output AWADDR, AWPROT, AWVALID, WDATA, WSTRB, WVALID, BREADY,
    output ARADDR, ARPROT, ARVALID, RREADY,
    input  AWREADY, WREADY, BRESP, BVALID, ARREADY, RDATA, RRESP, RVALID
  );

  modport slave (
    input  AWADDR, AWPROT, AWVALID, WDATA, WSTRB, WVALID, BREADY,
    input  ARADDR, ARPROT, ARVALID, RREADY,
    output AWREADY, WREADY, BRESP, BVALID, ARREADY, RDATA, RRESP, RVALID
  );
endinterface

// File: rtl/ro_counter_bank_axil.sv
// Ring-oscillator frequency bank: counts synchronised rising edges per channel over a gate window.
// Latency: edges counted 3 cycles after sampling; results latched G+2 cycles after start accept.
// Backpressure: AXI4-Lite, one transfer per 2 cycles per direction; B/R held until BREADY/RREADY.
// Ports: ACLK/ARESET (async active-high), ro_in (async oscillator inputs), ro_en (enables),
//        irq (level, done & irq_en), s_axi (AXI4-Lite slave register window).
module ro_counter_bank_axil #(
  parameter int NUM_CH             = 10,
  parameter int CNT_WIDTH          = 32,
  parameter int C_S_AXI_ADDR_WIDTH = 8
) (
  input  logic                 ACLK,
  input  logic                 ARESET,
  input  logic [NUM_CH-1:0]    ro_in,
  output logic [NUM_CH-1:0]    ro_en,
  output logic                 irq,
  ro_counter_bank_axil_if.slave s_axi
);

  localparam int IDX_W = C_S_AXI_ADDR_WIDTH - 2;
  localparam logic [CNT_WIDTH-1:0] CNT_MAX = '1;

  localparam logic [2:0] ST_IDLE  = 3'd0;
  localparam logic [2:0] ST_ARM   = 3'd1;
  localparam logic [2:0] ST_COUNT = 3'd2;
  localparam logic [2:0] ST_LATCH = 3'd3;
  localparam logic [2:0] ST_DONE  = 3'd4;

  // Per-byte write merge used by every WSTRB-aware register.
  function automatic logic [31:0] byte_merge(input logic [31:0] old_v,
                                             input logic [31:0] new_v,
                                             input logic [3:0]  strb);
    logic [31:0] res;
    for (int b = 0; b < 4; b++) begin
      res[8*b +: 8] = strb[b] ? new_v[8*b +: 8] : old_v[8*b +: 8];
    end
    return res;
  endfunction

  // AXI handshake state
  logic        awready_q, awready_d;
  logic        bvalid_q, bvalid_d;
  logic        arready_q, arready_d;
  logic        rvalid_q, rvalid_d;
  logic [31:0] rdata_q, rdata_d;

  // Software-visible registers
  logic              cont_q, cont_d;
  logic              irq_en_q, irq_en_d;
  logic              done_q, done_d;
  logic              ovf_q, ovf_d;
  logic [31:0]       gate_q, gate_d;
  logic [NUM_CH-1:0] enable_q, enable_d;
  logic [CNT_WIDTH-1:0] count_q [NUM_CH];
  logic [CNT_WIDTH-1:0] count_d [NUM_CH];

  // Measurement engine
  logic [2:0]           state_q, state_d;
  logic [31:0]          gate_cnt_q, gate_cnt_d;
  logic [NUM_CH-1:0]    chan_en_q, chan_en_d;
  logic [CNT_WIDTH-1:0] work_q [NUM_CH];
  logic [CNT_WIDTH-1:0] work_d [NUM_CH];
  logic                 ovf_hit;

  // Input synchroniser and edge detector
  logic [NUM_CH-1:0] sync1_q, sync2_q, prev_q;
  logic [NUM_CH-1:0] rise;

  // Write decode
  logic             wr_en, rd_en;
  logic [IDX_W-1:0] wr_idx, rd_idx;
  logic             wr_ctrl, wr_status, wr_gate, wr_enable;
  logic             ctrl_wr_b0, status_wr_b0;
  logic             start_wr, clear_wr, done_w1c, ovf_w1c;
  logic [31:0]      enable_ext, enable_mrg, rd_mux;
  logic             busy;

  assign rise = sync2_q & ~prev_q;
  assign busy = (state_q == ST_ARM) || (state_q == ST_COUNT) || (state_q == ST_LATCH);

  // awready_q is only raised while both valids are present and the master must hold them,
  // so its high cycle is exactly the accepting cycle.
  assign wr_en  = awready_q && s_axi.AWVALID && s_axi.WVALID;
  assign rd_en  = arready_q && s_axi.ARVALID;
  assign wr_idx = s_axi.AWADDR[C_S_AXI_ADDR_WIDTH-1:2];
  assign rd_idx = s_axi.ARADDR[C_S_AXI_ADDR_WIDTH-1:2];

  assign wr_ctrl      = wr_en && (wr_idx == IDX_W'(0));
  assign wr_status    = wr_en && (wr_idx == IDX_W'(1));
  assign wr_gate      = wr_en && (wr_idx == IDX_W'(2));
  assign wr_enable    = wr_en && (wr_idx == IDX_W'(3));
  assign ctrl_wr_b0   = wr_ctrl && s_axi.WSTRB[0];
  assign status_wr_b0 = wr_status && s_axi.WSTRB[0];
  // start acts directly on the accepting cycle so ARM follows one cycle later.
  assign start_wr = ctrl_wr_b0 && s_axi.WDATA[0];
  assign clear_wr = ctrl_wr_b0 && s_axi.WDATA[3];
  assign done_w1c = status_wr_b0 && s_axi.WDATA[1];
  assign ovf_w1c  = status_wr_b0 && s_axi.WDATA[2];

  always_comb begin
    enable_ext = '0;
    enable_ext[NUM_CH-1:0] = enable_q;
  end

  assign enable_mrg = byte_merge(enable_ext, s_axi.WDATA, s_axi.WSTRB);

  // AXI channel control
  always_comb begin
    awready_d = !awready_q && s_axi.AWVALID && s_axi.WVALID && !bvalid_q;
    arready_d = !arready_q && s_axi.ARVALID && !rvalid_q;
    bvalid_d  = bvalid_q;
    if (wr_en) begin
      bvalid_d = 1'b1;
    end else if (s_axi.BREADY) begin
      bvalid_d = 1'b0;
    end
    rvalid_d = rvalid_q;
    rdata_d  = rdata_q;
    if (rd_en) begin
      rvalid_d = 1'b1;
      rdata_d  = rd_mux;
    end else if (s_axi.RREADY) begin
      rvalid_d = 1'b0;
    end
  end

  // Read mux; unmapped addresses read 0
  always_comb begin
    rd_mux = '0;
    case (rd_idx)
      IDX_W'(0): begin
        rd_mux[1] = cont_q;
        rd_mux[2] = irq_en_q;
      end
      IDX_W'(1): begin
        rd_mux[0] = busy;
        rd_mux[1] = done_q;
        rd_mux[2] = ovf_q;
      end
      IDX_W'(2): rd_mux = gate_q;
      IDX_W'(3): rd_mux = enable_ext;
      default: begin
        for (int k = 0; k < NUM_CH; k++) begin
          if (rd_idx == IDX_W'(k + 4)) begin
            rd_mux[CNT_WIDTH-1:0] = count_q[k];
          end
        end
      end
    endcase
  end

  // Measurement FSM and working counters
  always_comb begin
    state_d    = state_q;
    gate_cnt_d = gate_cnt_q;
    chan_en_d  = chan_en_q;
    work_d     = work_q;
    ovf_hit    = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (start_wr) state_d = ST_ARM;
      end
      ST_ARM: begin
        for (int k = 0; k < NUM_CH; k++) work_d[k] = '0;
        gate_cnt_d = (gate_q == 32'd0) ? 32'd1 : gate_q;
        // Channel mask is frozen here so ENABLE writes mid-window only affect the next one.
        chan_en_d  = enable_q;
        state_d    = ST_COUNT;
      end
      ST_COUNT: begin
        for (int k = 0; k < NUM_CH; k++) begin
          if (chan_en_q[k] && rise[k]) begin
            if (work_q[k] == CNT_MAX) begin
              ovf_hit = 1'b1;
            end else begin
              work_d[k] = work_q[k] + CNT_WIDTH'(1);
            end
          end
        end
        if (gate_cnt_q == 32'd1) begin
          state_d = ST_LATCH;
        end else begin
          gate_cnt_d = gate_cnt_q - 32'd1;
        end
      end
      ST_LATCH: state_d = ST_DONE;
      ST_DONE:  state_d = cont_q ? ST_ARM : ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase
  end

  // Register file; hardware sets take priority over software clears.
  always_comb begin
    cont_d   = cont_q;
    irq_en_d = irq_en_q;
    gate_d   = gate_q;
    enable_d = enable_q;
    done_d   = done_q;
    ovf_d    = ovf_q;
    count_d  = count_q;
    if (ctrl_wr_b0) begin
      cont_d   = s_axi.WDATA[1];
      irq_en_d = s_axi.WDATA[2];
    end
    if (wr_gate)   gate_d   = byte_merge(gate_q, s_axi.WDATA, s_axi.WSTRB);
    if (wr_enable) enable_d = enable_mrg[NUM_CH-1:0];
    if (done_w1c) done_d = 1'b0;
    // done is raised leaving LATCH so it is visible during the DONE cycle.
    if (state_q == ST_LATCH) done_d = 1'b1;
    if (ovf_w1c || clear_wr) ovf_d = 1'b0;
    if (ovf_hit) ovf_d = 1'b1;
    if (clear_wr) begin
      for (int k = 0; k < NUM_CH; k++) count_d[k] = '0;
    end
    if (state_q == ST_LATCH) count_d = work_q;
  end

  always_ff @(posedge ACLK or posedge ARESET) begin
    if (ARESET) begin
      awready_q  <= 1'b0;
      bvalid_q   <= 1'b0;
      arready_q  <= 1'b0;
      rvalid_q   <= 1'b0;
      rdata_q    <= '0;
      cont_q     <= 1'b0;
      irq_en_q   <= 1'b0;
      done_q     <= 1'b0;
      ovf_q      <= 1'b0;
      gate_q     <= '0;
      enable_q   <= '0;
      state_q    <= ST_IDLE;
      gate_cnt_q <= '0;
      chan_en_q  <= '0;
      sync1_q    <= '0;
      sync2_q    <= '0;
      prev_q     <= '0;
      for (int k = 0; k < NUM_CH; k++) begin
        count_q[k] <= '0;
        work_q[k]  <= '0;
      end
    end else begin
      awready_q  <= awready_d;
      bvalid_q   <= bvalid_d;
      arready_q  <= arready_d;
      rvalid_q   <= rvalid_d;
      rdata_q    <= rdata_d;
      cont_q     <= cont_d;
      irq_en_q   <= irq_en_d;
      done_q     <= done_d;
      ovf_q      <= ovf_d;
      gate_q     <= gate_d;
      enable_q   <= enable_d;
      state_q    <= state_d;
      gate_cnt_q <= gate_cnt_d;
      chan_en_q  <= chan_en_d;
      sync1_q    <= ro_in;
      sync2_q    <= sync1_q;
      prev_q     <= sync2_q;
      count_q    <= count_d;
      work_q     <= work_d;
    end
  end

  assign s_axi.AWREADY = awready_q;
  assign s_axi.WREADY  = awready_q;
  assign s_axi.BVALID  = bvalid_q;
  assign s_axi.BRESP   = 2'b00;
  assign s_axi.ARREADY = arready_q;
  assign s_axi.RVALID  = rvalid_q;
  assign s_axi.RDATA   = rdata_q;
  assign s_axi.RRESP   = 2'b00;

  assign ro_en = enable_q;
  assign irq   = done_q & irq_en_q;

  // Protection bits, byte-lane address bits and the padding of the ENABLE merge carry no meaning.
  logic unused_ok;
  assign unused_ok = ^{s_axi.AWPROT, s_axi.ARPROT, s_axi.AWADDR[1:0], s_axi.ARADDR[1:0], enable_mrg};

endmodule

// File: tb/tb_ro_counter_bank_axil.sv
module tb_ro_counter_bank_axil;
  localparam int NUM_CH = 10;
  localparam int CNT_WIDTH = 8;
  localparam int AW = 8;

  logic              ACLK = 1'b0;
  logic              ARESET = 1'b1;
  logic [NUM_CH-1:0] ro_in;
  logic [NUM_CH-1:0] ro_en;
  logic              irq;

  ro_counter_bank_axil_if #(.ADDR_W(AW)) axi ();

  ro_counter_bank_axil #(
    .NUM_CH(NUM_CH),
    .CNT_WIDTH(CNT_WIDTH),
    .C_S_AXI_ADDR_WIDTH(AW)
  ) dut (
    .ACLK(ACLK),
    .ARESET(ARESET),
    .ro_in(ro_in),
    .ro_en(ro_en),
    .irq(irq),
    .s_axi(axi)
  );

  initial forever #5 ACLK = ~ACLK;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int per [NUM_CH] = '{default: 0};
  int ph  [NUM_CH] = '{default: 0};

  string       tag_q [$];
  logic [31:0] lo_q  [$];
  logic [31:0] hi_q  [$];
  logic [1:0]  last_bresp;
  logic [1:0]  last_rresp;

  initial forever begin
    @(posedge ACLK);
    cyc++;
  end

  // Oscillator model: channel k rises every per[k] cycles (0 = idle low).
  initial begin
    ro_in = '0;
    forever begin
      @(negedge ACLK);
      for (int k = 0; k < NUM_CH; k++) begin
        if (per[k] > 0) begin
          ro_in[k] = (ph[k] < per[k] / 2);
          ph[k] = (ph[k] + 1) % per[k];
        end else begin
          ro_in[k] = 1'b0;
        end
      end
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] lo, input logic [31:0] hi);
    checks++;
    if (lo == hi) begin
      assert (obs === lo) else begin
        errors++;
        $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, lo);
      end
    end else begin
      assert ((obs >= lo && obs <= hi) === 1'b1) else begin
        errors++;
        $error("FAIL %s observed=0x%0h expected=0x%0h..0x%0h", tag, obs, lo, hi);
      end
    end
  endtask

  task automatic axil_write(input logic [AW-1:0] addr, input logic [31:0] data,
                            input logic [3:0] strb);
    int  n;
    logic ok;
    @(negedge ACLK);
    axi.AWADDR  = addr;
    axi.WDATA   = data;
    axi.WSTRB   = strb;
    axi.AWVALID = 1'b1;
    axi.WVALID  = 1'b1;
    n = 0;
    while (!(axi.AWREADY && axi.WREADY) && n < 50) begin
      @(negedge ACLK);
      n++;
    end
    ok = axi.AWREADY && axi.WREADY;
    @(negedge ACLK);
    axi.AWVALID = 1'b0;
    axi.WVALID  = 1'b0;
    n = 0;
    while (!axi.BVALID && n < 50) begin
      @(negedge ACLK);
      n++;
    end
    last_bresp = axi.BRESP;
    if (!(ok && axi.BVALID)) chk($sformatf("wr_handshake_0x%0h", addr), 32'(ok && axi.BVALID), 1, 1);
  endtask

  // Expected range is queued when the read is issued and retired when RVALID appears.
  task automatic rd_chk(input logic [AW-1:0] addr, input string tag,
                        input logic [31:0] lo, input logic [31:0] hi);
    int          n;
    logic        ok;
    string       t;
    logic [31:0] elo, ehi;
    tag_q.push_back(tag);
    lo_q.push_back(lo);
    hi_q.push_back(hi);
    @(negedge ACLK);
    axi.ARADDR  = addr;
    axi.ARVALID = 1'b1;
    n = 0;
    while (!axi.ARREADY && n < 50) begin
      @(negedge ACLK);
      n++;
    end
    ok = axi.ARREADY;
    @(negedge ACLK);
    axi.ARVALID = 1'b0;
    n = 0;
    while (!axi.RVALID && n < 50) begin
      @(negedge ACLK);
      n++;
    end
    last_rresp = axi.RRESP;
    t   = tag_q.pop_front();
    elo = lo_q.pop_front();
    ehi = hi_q.pop_front();
    if (ok && axi.RVALID) chk(t, axi.RDATA, elo, ehi);
    else chk({t, "_handshake"}, 32'(ok && axi.RVALID), 1, 1);
  endtask

  task automatic wait_irq(input int bound, output int n);
    n = 0;
    while (!irq && n < bound) begin
      @(negedge ACLK);
      n++;
    end
  endtask

  initial begin
    int n, t1, t2, t3, ts;
    axi.AWADDR = '0; axi.AWPROT = '0; axi.AWVALID = 1'b0;
    axi.WDATA = '0; axi.WSTRB = '0; axi.WVALID = 1'b0; axi.BREADY = 1'b1;
    axi.ARADDR = '0; axi.ARPROT = '0; axi.ARVALID = 1'b0; axi.RREADY = 1'b1;
    last_bresp = '0;
    last_rresp = '0;

    // Reset state
    ARESET = 1'b1;
    repeat (3) @(negedge ACLK);
    chk("rst_ro_en", 32'(ro_en), 0, 0);
    chk("rst_irq", 32'(irq), 0, 0);
    ARESET = 1'b0;
    rd_chk(8'h04, "rst_status", 0, 0);
    rd_chk(8'h10, "rst_count0", 0, 0);

    // Register access
    axil_write(8'h0C, 32'h3FF, 4'hF);
    chk("bresp", 32'(last_bresp), 0, 0);
    axil_write(8'h08, 32'h64, 4'hF);
    rd_chk(8'h0C, "enable_rb", 32'h3FF, 32'h3FF);
    rd_chk(8'h08, "gate_rb", 32'h64, 32'h64);
    chk("ro_en_3ff", 32'(ro_en), 32'h3FF, 32'h3FF);
    rd_chk(8'hFC, "unmapped", 0, 0);
    chk("rresp_unmapped", 32'(last_rresp), 0, 0);
    axil_write(8'h08, 32'hAABBCCDD, 4'b0010);
    rd_chk(8'h08, "gate_wstrb", 32'h0000CC64, 32'h0000CC64);

    // Single measurement, GATE=1000
    for (int k = 0; k < NUM_CH; k++) per[k] = 8 * (k + 1);
    axil_write(8'h08, 32'd1000, 4'hF);
    axil_write(8'h00, 32'h5, 4'hF);
    wait_irq(1200, n);
    chk("done_latency", 32'(n), 32'd1002, 32'd1002);
    rd_chk(8'h04, "meas_status", 32'h2, 32'h2);
    rd_chk(8'h00, "ctrl_start_self_clear", 32'h4, 32'h4);
    for (int k = 0; k < NUM_CH; k++) begin
      rd_chk(8'(16 + 4 * k), $sformatf("meas_count%0d", k),
             32'(1000 / (8 * (k + 1)) - 1), 32'(1000 / (8 * (k + 1)) + 1));
    end
    chk("meas_irq", 32'(irq), 1, 1);
    axil_write(8'h04, 32'h2, 4'hF);
    chk("irq_drop_after_w1c", 32'(irq), 0, 0);

    // Disabled channels
    axil_write(8'h0C, 32'h001, 4'hF);
    chk("ro_en_001", 32'(ro_en), 1, 1);
    axil_write(8'h08, 32'd200, 4'hF);
    axil_write(8'h00, 32'h5, 4'hF);
    wait_irq(400, n);
    rd_chk(8'h10, "dis_count0", 32'd24, 32'd26);
    for (int k = 1; k < NUM_CH; k++) rd_chk(8'(16 + 4 * k), $sformatf("dis_count%0d", k), 0, 0);
    axil_write(8'h04, 32'h2, 4'hF);

    // Saturation at 8 bits
    per[0] = 4;
    axil_write(8'h08, 32'd2000, 4'hF);
    axil_write(8'h00, 32'h5, 4'hF);
    wait_irq(2200, n);
    rd_chk(8'h10, "sat_count0", 32'd255, 32'd255);
    rd_chk(8'h04, "sat_status_ovf", 32'h6, 32'h6);
    axil_write(8'h00, 32'hC, 4'hF);
    rd_chk(8'h10, "clear_count0", 0, 0);
    rd_chk(8'h04, "clear_status", 32'h2, 32'h2);
    axil_write(8'h04, 32'h2, 4'hF);

    // Continuous mode, GATE=50
    per[0] = 8;
    axil_write(8'h0C, 32'h3FF, 4'hF);
    axil_write(8'h08, 32'd50, 4'hF);
    axil_write(8'h00, 32'h7, 4'hF);
    wait_irq(100, n);
    t1 = cyc;
    axil_write(8'h04, 32'h2, 4'hF);
    wait_irq(100, n);
    t2 = cyc;
    chk("cont_period1", 32'(t2 - t1), 32'd53, 32'd53);
    axil_write(8'h04, 32'h2, 4'hF);
    wait_irq(100, n);
    t3 = cyc;
    chk("cont_period2", 32'(t3 - t2), 32'd53, 32'd53);
    rd_chk(8'h10, "cont_count0", 32'd5, 32'd7);

    // Stop continuous mid-window: current window completes, then idle
    axil_write(8'h04, 32'h2, 4'hF);
    axil_write(8'h00, 32'h4, 4'hF);
    wait_irq(100, n);
    chk("stop_last_window", 32'(irq), 1, 1);
    axil_write(8'h04, 32'h2, 4'hF);
    wait_irq(150, n);
    chk("stop_idle_no_done", 32'(n), 32'd150, 32'd150);
    rd_chk(8'h04, "stop_status", 0, 0);

    // Restart; a second start while busy must be ignored
    axil_write(8'h00, 32'h5, 4'hF);
    ts = cyc;
    axil_write(8'h00, 32'h5, 4'hF);
    rd_chk(8'h04, "restart_busy", 32'h1, 32'h1);
    wait_irq(100, n);
    chk("restart_latency", 32'(cyc - ts), 32'd52, 32'd52);
    axil_write(8'h04, 32'h2, 4'hF);
    wait_irq(150, n);
    chk("restart_no_extra", 32'(n), 32'd150, 32'd150);

    // Asynchronous reset mid-window
    axil_write(8'h08, 32'd1000, 4'hF);
    axil_write(8'h00, 32'h5, 4'hF);
    repeat (100) @(negedge ACLK);
    ARESET = 1'b1;
    #1;
    chk("arst_ro_en", 32'(ro_en), 0, 0);
    chk("arst_irq", 32'(irq), 0, 0);
    @(negedge ACLK);
    ARESET = 1'b0;
    rd_chk(8'h00, "arst_ctrl", 0, 0);
    rd_chk(8'h04, "arst_status", 0, 0);
    rd_chk(8'h08, "arst_gate", 0, 0);
    rd_chk(8'h0C, "arst_enable", 0, 0);
    for (int k = 0; k < NUM_CH; k++) rd_chk(8'(16 + 4 * k), $sformatf("arst_count%0d", k), 0, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
